condiciona_sensores: RTL and testbench

CONDICIONA_SENSORES -- requirements
Module: condiciona_sensores

---
 rtl/condiciona_sensores.sv | 147 ++++++++++++++
 tb/tb_condiciona_sensores.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/condiciona_sensores.sv
// -----------------------------------------------------------------------------
// condiciona_sensores
//
// Debounce and chatter supervision for four raw switch inputs
// (bit0 Us, bit1 Ua, bit2 T, bit3 agroDef).
//
// Each raw level is first brought into the clock domain by a two-flop
// synchronizer that runs every clock. A channel's filtered level changes only
// after the synchronized level has disagreed with it for ESTAVEL consecutive
// tick samples. A transition that starts and is then abandoned before
// completing counts as a bounce. LIMITE_OSC bounces without an intervening
// completed transition latch that channel's fault flag until reset. Filtering
// continues normally on a faulted channel.
//
// Ports
//   clockPlaca   in   1  system clock, rising edge
//   resetN       in   1  synchronous, active-low reset
//   tick         in   1  single-cycle sample enable; filters advance only here
//   sensores_in  in   4  raw asynchronous switch levels
//   sensores_out out  4  debounced levels, same bit order
//   mudou        out  1  one-clock pulse after any sensores_out bit changed
//   falha        out  4  sticky per-channel chatter fault
// -----------------------------------------------------------------------------
module condiciona_sensores #(
    parameter int ESTAVEL    = 8,   // legal range 2..15
    parameter int LIMITE_OSC = 15   // legal range 1..15
) (
    input  logic       clockPlaca,
    input  logic       resetN,
    input  logic       tick,
    input  logic [3:0] sensores_in,
    output logic [3:0] sensores_out,
    output logic       mudou,
    output logic [3:0] falha
);

    localparam int         NUM_CANAIS = 4;
    localparam logic [3:0] CNT_TOP    = 4'(ESTAVEL - 1);
    localparam logic [3:0] OSC_LIM    = 4'(LIMITE_OSC);
    localparam logic [3:0] OSC_MAX    = 4'hF;

    // Two-flop synchronizer; sync2_reg is the level the filters look at.
    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;

    // Per-channel results gathered into vectors.
    logic [3:0] out_bits;
    logic [3:0] falha_bits;
    logic [3:0] change_bits;

    logic mudou_reg;

    always_ff @(posedge clockPlaca) begin
        if (!resetN) begin
            sync1_reg <= 4'b0000;
            sync2_reg <= 4'b0000;
        end else begin
            sync1_reg <= sensores_in;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CANAIS; gi = gi + 1) begin : g_canal
            logic [3:0] cnt_reg;
            logic [3:0] cnt_next;
            logic [3:0] osc_reg;
            logic [3:0] osc_next;
            logic       out_reg;
            logic       out_next;
            logic       falha_reg;
            logic       falha_next;
            logic       differs;
            logic       at_top;

            assign differs = sync2_reg[gi] ^ out_reg;
            // >= rather than == keeps the counter from ever running past the
            // commit point, so it can never wrap.
            assign at_top  = (cnt_reg >= CNT_TOP);

            always_comb begin
                cnt_next   = cnt_reg;
                osc_next   = osc_reg;
                out_next   = out_reg;
                falha_next = falha_reg;
                if (tick) begin
                    if (differs) begin
                        if (at_top) begin
                            // Stable long enough: commit the new level.
                            out_next = sync2_reg[gi];
                            cnt_next = 4'd0;
                            osc_next = 4'd0;
                        end else begin
                            cnt_next = cnt_reg + 4'd1;
                        end
                    end else if (cnt_reg != 4'd0) begin
                        // Input went back before committing: a bounce.
                        cnt_next = 4'd0;
                        if (osc_reg != OSC_MAX) begin
                            osc_next = osc_reg + 4'd1;
                        end
                    end
                    // Checked against the updated count so the flag sets on
                    // the same edge the limit is reached.
                    if (osc_next >= OSC_LIM) begin
                        falha_next = 1'b1;
                    end
                end
            end

            always_ff @(posedge clockPlaca) begin
                if (!resetN) begin
                    cnt_reg   <= 4'd0;
                    osc_reg   <= 4'd0;
                    out_reg   <= 1'b0;
                    falha_reg <= 1'b0;
                end else begin
                    cnt_reg   <= cnt_next;
                    osc_reg   <= osc_next;
                    out_reg   <= out_next;
                    falha_reg <= falha_next;
                end
            end

            assign out_bits[gi]    = out_reg;
            assign falha_bits[gi]  = falha_reg;
            assign change_bits[gi] = out_next ^ out_reg;
        end
    endgenerate

    // Registered together with the output bits, so the pulse occupies exactly
    // the clock after the edge that changed them; several channels changing
    // together still produce one pulse.
    always_ff @(posedge clockPlaca) begin
        if (!resetN) begin
            mudou_reg <= 1'b0;
        end else begin
            mudou_reg <= |change_bits;
        end
    end

    assign sensores_out = out_bits;
    assign falha        = falha_bits;
    assign mudou        = mudou_reg;

endmodule

// File: tb/tb_condiciona_sensores.sv
module tb_condiciona_sensores;

    logic       clk;
    logic       resetN;
    logic       tick;
    logic [3:0] sensores_in;
    logic [3:0] sensores_out;
    logic       mudou;
    logic [3:0] falha;

    typedef struct {
        logic [3:0] out;
        int         tk;
    } exp_t;

    exp_t exp_q[$];

    int   total;
    int   bad;
    int   ticks;
    logic [1:0] phase;
    logic tick_en;

    condiciona_sensores #(
        .ESTAVEL   (8),
        .LIMITE_OSC(3)
    ) dut (
        .clockPlaca  (clk),
        .resetN      (resetN),
        .tick        (tick),
        .sensores_in (sensores_in),
        .sensores_out(sensores_out),
        .mudou       (mudou),
        .falha       (falha)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
        $display("check %s observed=%b expected=%b", tag, obs, expv);
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        total++;
        assert (obs == expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    // Scoreboard consumer: every mudou pulse must match the oldest expected
    // change, both in output value and in the tick on which it occurred.
    task automatic monitor();
        exp_t e;
        if (mudou === 1'b1) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL spurious_mudou observed=1 expected=0 out=%b tick=%0d", sensores_out, ticks);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("mudou_out", sensores_out, e.out);
                chk_int("mudou_tick", ticks, e.tk);
            end
        end
    endtask

    // One clock: tick driven at the falling edge, outputs sampled 1 ns after
    // the rising edge.
    task automatic cyc();
        @(negedge clk);
        tick  = tick_en && (phase == 2'd0);
        phase = phase + 2'd1;
        @(posedge clk);
        if (tick) ticks++;
        #1;
        monitor();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic run_ticks(input int n);
        int target;
        int budget;
        target = ticks + n;
        budget = 4 * n + 8;
        while (ticks < target && budget > 0) begin
            cyc();
            budget--;
        end
    endtask

    // Expect a change on the 8th tick counted after the two synchronizer
    // clocks that follow an input edge.
    task automatic expect_change(input logic [3:0] outv);
        exp_t e;
        run_cycles(2);
        e.out = outv;
        e.tk  = ticks + 8;
        exp_q.push_back(e);
    endtask

    task automatic chk_pending(input string tag);
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=0", tag, exp_q.size());
        end
        $display("check %s pending=%0d", tag, exp_q.size());
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        ticks       = 0;
        phase       = 2'd0;
        tick_en     = 1'b1;
        tick        = 1'b0;
        resetN      = 1'b0;
        sensores_in = 4'b0000;

        // Reset state
        run_cycles(3);
        chk("reset_out", sensores_out, 4'b0000);
        chk("reset_mudou", {3'b000, mudou}, 4'b0000);
        chk("reset_falha", falha, 4'b0000);
        resetN = 1'b1;
        run_cycles(4);
        chk("idle_out", sensores_out, 4'b0000);

        // Us raised and held
        sensores_in = 4'b0001;
        expect_change(4'b0001);
        run_ticks(10);
        chk_pending("us_rise_pending");
        chk("us_rise_out", sensores_out, 4'b0001);
        chk("us_rise_falha", falha, 4'b0000);

        // Ua bounces: 5 ticks high then low, three times
        for (int r = 0; r < 3; r++) begin
            sensores_in = 4'b0011;
            run_cycles(2);
            run_ticks(5);
            sensores_in = 4'b0001;
            run_cycles(2);
            run_ticks(1);
            chk("ua_bounce_out", sensores_out, 4'b0001);
            chk("ua_bounce_falha", falha, (r == 2) ? 4'b0010 : 4'b0000);
        end

        // T and agroDef together: one pulse, both bits on the same edge
        sensores_in = 4'b1101;
        expect_change(4'b1101);
        run_ticks(10);
        chk_pending("t_agro_pending");
        chk("t_agro_out", sensores_out, 4'b1101);

        // Input toggling with tick held low changes nothing
        tick_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sensores_in = sensores_in ^ 4'b1111;
            cyc();
        end
        sensores_in = 4'b1101;
        run_cycles(3);
        chk("notick_out", sensores_out, 4'b1101);
        chk("notick_falha", falha, 4'b0010);
        tick_en = 1'b1;
        run_ticks(10);
        chk("notick_after_out", sensores_out, 4'b1101);
        chk("notick_after_falha", falha, 4'b0010);

        // Faulted channel still filters, fault stays latched
        sensores_in = 4'b1111;
        expect_change(4'b1111);
        run_ticks(10);
        chk_pending("ua_fault_follow_pending");
        chk("ua_fault_follow_out", sensores_out, 4'b1111);
        chk("ua_fault_sticky", falha, 4'b0010);

        // Reset clears everything, including the latched fault
        resetN      = 1'b0;
        sensores_in = 4'b0000;
        run_cycles(2);
        resetN = 1'b1;
        chk("reset2_out", sensores_out, 4'b0000);
        chk("reset2_falha", falha, 4'b0000);
        chk("reset2_mudou", {3'b000, mudou}, 4'b0000);
        run_cycles(3);

        // Transition in progress is discarded by reset and restarts from 0
        sensores_in = 4'b0001;
        run_cycles(2);
        run_ticks(6);
        chk("us_partial_out", sensores_out, 4'b0000);
        resetN = 1'b0;
        cyc();
        resetN = 1'b1;
        chk("reset3_out", sensores_out, 4'b0000);
        chk("reset3_mudou", {3'b000, mudou}, 4'b0000);
        expect_change(4'b0001);
        run_ticks(10);
        chk_pending("us_restart_pending");
        chk("us_restart_out", sensores_out, 4'b0001);
        chk("us_restart_falha", falha, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
